// File: rtl/nios_pio_in_filtered.sv
// Avalon-MM input PIO with per-bit synchroniser, debounce filter, edge capture and maskable irq.
// Register map: 0 DATA (RO), 1 reserved, 2 IRQ_MASK (RW), 3 EDGE_CAPTURE (write-1-to-clear).
module nios_pio_in_filtered #(
    parameter int unsigned WIDTH           = 9,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned EDGE_TYPE       = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES == 0) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE = 2'd3;

    logic [WIDTH-1:0] r_sync [SYNC_STAGES];
    logic [WIDTH-1:0] w_sync_q;
    logic [WIDTH-1:0] r_filt;
    logic [WIDTH-1:0] r_filt_d;
    logic [WIDTH-1:0] r_irq_mask;
    logic [WIDTH-1:0] r_edge_cap;
    logic [WIDTH-1:0] w_event;
    logic [WIDTH-1:0] w_clear;
    logic             w_write;
    logic [31:0]      w_rd_mux;
    logic [31:0]      r_readdata;
    logic             r_irq;

    assign readdata = r_readdata;
    assign irq      = r_irq;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                r_sync[s] <= '0;
            end
        end else begin
            r_sync[0] <= in_port;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                r_sync[s] <= r_sync[s-1];
            end
        end
    end

    assign w_sync_q = r_sync[SYNC_STAGES-1];

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_filt <= '0;
                end else begin
                    r_filt <= w_sync_q;
                end
            end
        end else begin : g_debounce
            localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

            logic [CNT_W-1:0] r_cnt [WIDTH];

            // A bit is accepted on the cycle its counter would reach DEBOUNCE_CYCLES.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_filt <= '0;
                    for (int i = 0; i < WIDTH; i++) begin
                        r_cnt[i] <= '0;
                    end
                end else begin
                    for (int i = 0; i < WIDTH; i++) begin
                        if (w_sync_q[i] == r_filt[i]) begin
                            r_cnt[i] <= '0;
                        end else if (r_cnt[i] == CNT_LAST) begin
                            r_filt[i] <= w_sync_q[i];
                            r_cnt[i]  <= '0;
                        end else begin
                            r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                        end
                    end
                end
            end
        end
    endgenerate

    generate
        if (EDGE_TYPE == 0) begin : g_rise
            assign w_event = r_filt & ~r_filt_d;
        end else if (EDGE_TYPE == 1) begin : g_fall
            assign w_event = ~r_filt & r_filt_d;
        end else begin : g_any
            assign w_event = r_filt ^ r_filt_d;
        end
    endgenerate

    assign w_write = chipselect & ~write_n;
    assign w_clear = (w_write && (address == ADDR_EDGE)) ? writedata[WIDTH-1:0] : '0;

    always_comb begin
        w_rd_mux = '0;
        case (address)
            ADDR_DATA: w_rd_mux[WIDTH-1:0] = r_filt;
            ADDR_MASK: w_rd_mux[WIDTH-1:0] = r_irq_mask;
            ADDR_EDGE: w_rd_mux[WIDTH-1:0] = r_edge_cap;
            default:   w_rd_mux = '0;
        endcase
    end

    // New events are OR-ed in after the clear so a same-cycle set beats write-1-to-clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_filt_d   <= '0;
            r_irq_mask <= '0;
            r_edge_cap <= '0;
            r_readdata <= '0;
            r_irq      <= 1'b0;
        end else begin
            r_filt_d   <= r_filt;
            r_edge_cap <= (r_edge_cap & ~w_clear) | w_event;
            r_readdata <= w_rd_mux;
            r_irq      <= |(r_edge_cap & r_irq_mask);
            if (w_write && (address == ADDR_MASK)) begin
                r_irq_mask <= writedata[WIDTH-1:0];
            end
        end
    end

endmodule

// File: tb/tb_nios_pio_in_filtered.sv
// Bench for nios_pio_in_filtered: four parameterisations share one bus, checked every cycle
// against a window-based behavioural model, plus directed literal checks.
module tb_nios_pio_in_filtered;

    localparam int NI = 4;
    localparam int P_W [NI] = '{9, 9, 9, 32};
    localparam int P_S [NI] = '{2, 2, 3, 2};
    localparam int P_D [NI] = '{4, 4, 2, 0};
    localparam int P_E [NI] = '{0, 1, 2, 0};

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address = 2'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [31:0] inp [NI];
    logic [31:0] rdata [NI];
    logic        irqo [NI];

    int   vectors = 0;
    int   mism = 0;
    logic chk_en = 1'b0;

    always #5 clk = ~clk;

    nios_pio_in_filtered #(.WIDTH(9), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(0)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rdata[0]), .in_port(inp[0][8:0]),
        .irq(irqo[0]));
    nios_pio_in_filtered #(.WIDTH(9), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(1)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rdata[1]), .in_port(inp[1][8:0]),
        .irq(irqo[1]));
    nios_pio_in_filtered #(.WIDTH(9), .SYNC_STAGES(3), .DEBOUNCE_CYCLES(2), .EDGE_TYPE(2)) u_dut2 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rdata[2]), .in_port(inp[2][8:0]),
        .irq(irqo[2]));
    nios_pio_in_filtered #(.WIDTH(32), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(0)) u_dut3 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rdata[3]), .in_port(inp[3]),
        .irq(irqo[3]));

    // Model: hist holds the raw input sampled at each clock edge; filt accepts a new value
    // once the synchronised input has shown it for DEBOUNCE_CYCLES consecutive edges.
    logic [31:0] hist [NI][64];
    int          lastch [NI][32];
    logic [31:0] m_filt [NI];
    logic [31:0] m_filtd [NI];
    logic [31:0] m_cap [NI];
    logic [31:0] m_mask [NI];
    logic [31:0] m_rd [NI];
    logic        m_irq [NI];
    int          ec = 1000;

    function automatic logic [31:0] wmask(input int n);
        return (P_W[n] == 32) ? 32'hFFFF_FFFF : ((32'h1 << P_W[n]) - 32'h1);
    endfunction

    function automatic logic [31:0] seen(input int n, input int j);
        return hist[n][(j - P_S[n]) & 63];
    endfunction

    initial begin
        logic [31:0] wm, cur, tmp, nf, ev, clr, nrd;
        logic        wr, ok;
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                for (int n = 0; n < NI; n++) begin
                    m_filt[n] = '0; m_filtd[n] = '0; m_cap[n] = '0;
                    m_mask[n] = '0; m_rd[n] = '0; m_irq[n] = 1'b0;
                    for (int e = 0; e < 64; e++) hist[n][e] = '0;
                    for (int b = 0; b < 32; b++) lastch[n][b] = 0;
                end
            end else begin
                ec++;
                for (int n = 0; n < NI; n++) begin
                    wm = wmask(n);
                    hist[n][ec & 63] = inp[n] & wm;
                    cur = seen(n, ec);
                    nf = m_filt[n];
                    if (P_D[n] == 0) begin
                        nf = cur;
                    end else begin
                        for (int b = 0; b < P_W[n]; b++) begin
                            if (cur[b] != m_filt[n][b] && (ec - P_D[n] + 1) > lastch[n][b]) begin
                                ok = 1'b1;
                                for (int j = ec - P_D[n] + 1; j <= ec; j++) begin
                                    tmp = seen(n, j);
                                    if (tmp[b] != cur[b]) ok = 1'b0;
                                end
                                if (ok) begin
                                    nf[b] = cur[b];
                                    lastch[n][b] = ec;
                                end
                            end
                        end
                    end
                    case (P_E[n])
                        0:       ev = m_filt[n] & ~m_filtd[n];
                        1:       ev = ~m_filt[n] & m_filtd[n];
                        default: ev = m_filt[n] ^ m_filtd[n];
                    endcase
                    wr  = chipselect && !write_n;
                    clr = (wr && address == 2'd3) ? (writedata & wm) : '0;
                    case (address)
                        2'd0:    nrd = m_filt[n];
                        2'd2:    nrd = m_mask[n];
                        2'd3:    nrd = m_cap[n];
                        default: nrd = '0;
                    endcase
                    m_irq[n] = |(m_cap[n] & m_mask[n]);
                    m_rd[n]  = nrd;
                    m_cap[n] = (m_cap[n] & ~clr) | ev;
                    if (wr && address == 2'd2) m_mask[n] = writedata & wm;
                    m_filtd[n] = m_filt[n];
                    m_filt[n]  = nf;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                for (int n = 0; n < NI; n++) begin
                    vectors++;
                    if (rdata[n] !== m_rd[n]) begin
                        mism++;
                        $display("FAIL model readdata[%0d] t=%0t got %h want %h",
                                 n, $time, rdata[n], m_rd[n]);
                    end
                    vectors++;
                    if (irqo[n] !== m_irq[n]) begin
                        mism++;
                        $display("FAIL model irq[%0d] t=%0t got %b want %b",
                                 n, $time, irqo[n], m_irq[n]);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            mism++;
            $display("FAIL %s t=%0t got %h want %h", name, $time, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic set_in(input logic [31:0] v);
        for (int n = 0; n < NI; n++) inp[n] = v & wmask(n);
    endtask

    task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        cyc(1);
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic bus_rd(input logic [1:0] a);
        address = a;
        cyc(1);
    endtask

    initial begin
        reset_n = 1'b0;
        set_in('0);
        @(negedge clk); #1;
        chk_en = 1'b1;
        chk("reset readdata", rdata[0], 32'h0);
        chk("reset irq", {31'b0, irqo[0]}, 32'h0);
        reset_n = 1'b1;
        cyc(2);
        for (int a = 0; a < 4; a++) begin
            bus_rd(2'(a));
            chk("idle readdata", rdata[0], 32'h0);
        end

        // Latency: DATA visible at edge 7 (filt at edge 6); bypassed 32-bit at edge 4.
        address = 2'd0;
        set_in(32'h1A5);
        inp[3] = 32'hFFFF_FFFF;
        cyc(3); chk("bypass early", rdata[3], 32'h0);
        cyc(1); chk("bypass data", rdata[3], 32'hFFFF_FFFF);
        cyc(2); chk("data early", rdata[0], 32'h0);
        cyc(1); chk("data 1A5", rdata[0], 32'h1A5);
        cyc(13);
        bus_rd(2'd3);
        chk("cap rise", rdata[0], 32'h1A5);
        chk("cap fall none", rdata[1], 32'h0);
        chk("cap any", rdata[2], 32'h1A5);

        // Glitch on bit 3 shorter than the debounce window.
        bus_wr(2'd3, 32'hFFFF_FFFF);
        set_in(32'h1AD); cyc(3); set_in(32'h1A5); cyc(12);
        bus_rd(2'd0); chk("glitch data", rdata[0], 32'h1A5);
        bus_rd(2'd3); chk("glitch cap", rdata[0], 32'h0);
        chk("glitch irq", {31'b0, irqo[0]}, 32'h0);
        set_in(32'h1AD); cyc(12);
        bus_rd(2'd0); chk("held data", rdata[0], 32'h1AD);
        bus_rd(2'd3); chk("held cap", rdata[0], 32'h8);

        // Interrupt flow.
        bus_wr(2'd3, 32'hFFFF_FFFF);
        bus_wr(2'd2, 32'h8);
        set_in(32'h1A5); cyc(10);
        chk("fall no irq", {31'b0, irqo[0]}, 32'h0);
        address = 2'd3;
        set_in(32'h1AD);
        cyc(7); chk("irq before", {31'b0, irqo[0]}, 32'h0);
        chk("cap before", rdata[0], 32'h0);
        cyc(1); chk("irq set", {31'b0, irqo[0]}, 32'h1);
        chk("cap set", rdata[0], 32'h8);
        bus_wr(2'd3, 32'h8);
        chk("irq lag", {31'b0, irqo[0]}, 32'h1);
        cyc(1); chk("irq cleared", {31'b0, irqo[0]}, 32'h0);
        chk("cap cleared", rdata[0], 32'h0);
        set_in(32'h1AC); cyc(10); set_in(32'h1AD); cyc(10);
        bus_rd(2'd3); chk("masked cap", rdata[0], 32'h1);
        chk("masked irq", {31'b0, irqo[0]}, 32'h0);

        // Clear and rising event on bit 5 in the same cycle.
        bus_wr(2'd3, 32'hFFFF_FFFF);
        set_in(32'h18D); cyc(10);
        bus_wr(2'd3, 32'hFFFF_FFFF);
        set_in(32'h1AD);
        cyc(6);
        bus_wr(2'd3, 32'h20);
        cyc(1); chk("collision", rdata[0], 32'h20);

        // Edge types on bit 8.
        bus_wr(2'd3, 32'hFFFF_FFFF);
        set_in(32'h0AD); cyc(10);
        bus_wr(2'd3, 32'hFFFF_FFFF);
        set_in(32'h1AD); cyc(10);
        bus_rd(2'd3);
        chk("fall type rise", rdata[1], 32'h0);
        chk("any type rise", rdata[2], 32'h100);
        bus_wr(2'd3, 32'hFFFF_FFFF);
        set_in(32'h0AD); cyc(10);
        bus_rd(2'd3);
        chk("fall type fall", rdata[1], 32'h100);
        chk("any type fall", rdata[2], 32'h100);

        // Async reset in the middle of debounce.
        bus_wr(2'd2, 32'h1FF);
        bus_rd(2'd0); chk("pre-reset data", rdata[0], 32'h0AD);
        set_in(32'h1FF);
        cyc(3);
        reset_n = 1'b0;
        #1;
        for (int n = 0; n < NI; n++) begin
            chk("async rd", rdata[n], 32'h0);
            chk("async irq", {31'b0, irqo[n]}, 32'h0);
        end
        @(negedge clk); @(negedge clk); #2;
        reset_n = 1'b1;
        cyc(6); chk("requal early", rdata[0], 32'h0);
        cyc(1); chk("requal data", rdata[0], 32'h1FF);
        bus_rd(2'd3); chk("requal cap", rdata[0], 32'h1FF);

        // Randomised traffic.
        for (int c = 0; c < 1500; c++) begin
            for (int n = 0; n < NI; n++) begin
                if ($urandom_range(0, 7) == 0) inp[n] = inp[n] ^ (($urandom() & $urandom()) & wmask(n));
            end
            address    = 2'($urandom_range(0, 3));
            chipselect = 1'($urandom_range(0, 1));
            write_n    = ($urandom_range(0, 3) != 0);
            writedata  = $urandom() & $urandom();
            cyc(1);
        end
        chipselect = 1'b0; write_n = 1'b1;
        cyc(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, mism);
        $finish;
    end

endmodule
